// File: rtl/wb_stage_if.sv
// Memory-to-writeback handshake: valid/bus from MEM, allowin back from WB.
interface wb_stage_if;
  logic         wb_allowin;
  logic         mem_wb_valid;
  logic [184:0] mem_wb_bus;

  // MEM-stage side
  modport master (
    output mem_wb_valid,
    output mem_wb_bus,
    input  wb_allowin
  );

  // WB-stage side
  modport slave (
    input  mem_wb_valid,
    input  mem_wb_bus,
    output wb_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM->WB bus, commits register-file writes,
// hosts the CSR file (CRMD, PRMD, ESTAT, ERA, EENTRY, SAVE0-3), commits
// syscall/ertn and drives the flush redirect and the bypass bus to decode.
// Optional build macro: WB_DEBUG_TRACE_EN enables the debug_wb_* trace ports;
// when undefined they are tied to zero.
module wb_stage (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   mem_wb,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_ex,
  output logic [31:0] flush_pc,
  output logic [53:0] wb_id_bus,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef struct packed {
    logic        rsvd;
    logic        gr_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall_ex;
  } mem_wb_bus_t;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [5:0]  ECODE_SYS  = 6'h0B;

  // Pipeline registers
  logic        wb_valid_q, wb_valid_d;
  mem_wb_bus_t bus_q, bus_d;

  // CSR fields (only the architecturally implemented bits are stored)
  logic [1:0]  crmd_plv_q, crmd_plv_d;
  logic        crmd_ie_q, crmd_ie_d;
  logic        crmd_da_q, crmd_da_d;
  logic [1:0]  prmd_pplv_q, prmd_pplv_d;
  logic        prmd_pie_q, prmd_pie_d;
  logic [1:0]  estat_is_q, estat_is_d;
  logic [5:0]  estat_ecode_q, estat_ecode_d;
  logic [8:0]  estat_esub_q, estat_esub_d;
  logic [31:0] era_q, era_d;
  logic [25:0] eentry_va_q, eentry_va_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];

  logic [31:0] csr_rvalue;
  logic [31:0] csr_merged;
  logic        csr_wr_en;
  logic        wb_bypass;
  logic        wb_csr;

  assign mem_wb.wb_allowin = 1'b1;

  // Next-state of the pipeline register: valid follows upstream, bus loads on valid.
  always_comb begin
    wb_valid_d = mem_wb.mem_wb_valid;
    bus_d      = mem_wb.mem_wb_valid ? mem_wb_bus_t'(mem_wb.mem_wb_bus) : bus_q;
  end

  // Exception/return outputs and register-file commit.
  always_comb begin
    wb_ex     = wb_valid_q & (bus_q.syscall_ex | bus_q.ertn);
    flush_pc  = bus_q.syscall_ex ? {eentry_va_q, 6'b0} : era_q;
    rf_we     = wb_valid_q & bus_q.gr_we & ~wb_ex;
    rf_waddr  = bus_q.dest;
    rf_wdata  = bus_q.csr_re ? csr_rvalue : bus_q.final_result;
    wb_bypass = wb_valid_q & bus_q.gr_we;
    wb_csr    = wb_valid_q & (bus_q.csr_we | bus_q.csr_re);
    wb_id_bus = {wb_bypass, bus_q.dest, rf_wdata, bus_q.gr_we, wb_csr, bus_q.csr_num};
  end

  // Combinational CSR read; unimplemented numbers read as zero.
  always_comb begin
    case (bus_q.csr_num)
      CSR_CRMD:   csr_rvalue = {28'b0, crmd_da_q, crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd_pie_q, prmd_pplv_q};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esub_q, estat_ecode_q, 14'b0, estat_is_q};
      CSR_ERA:    csr_rvalue = era_q;
      CSR_EENTRY: csr_rvalue = {eentry_va_q, 6'b0};
      CSR_SAVE0:  csr_rvalue = save_q[0];
      CSR_SAVE1:  csr_rvalue = save_q[1];
      CSR_SAVE2:  csr_rvalue = save_q[2];
      CSR_SAVE3:  csr_rvalue = save_q[3];
      default:    csr_rvalue = 32'b0;
    endcase
  end

  // CSR next-state: syscall, then ertn, then masked software write.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    crmd_da_d     = crmd_da_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    estat_is_d    = estat_is_q;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    eentry_va_d   = eentry_va_q;
    save_d        = save_q;
    // The selected CSR's current value is exactly csr_rvalue, so merge against it.
    csr_merged    = (csr_rvalue & ~bus_q.csr_wmask) | (bus_q.csr_wvalue & bus_q.csr_wmask);
    csr_wr_en     = wb_valid_q & bus_q.csr_we & ~wb_ex;

    if (wb_valid_q && bus_q.syscall_ex) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'b0;
      crmd_ie_d     = 1'b0;
      era_d         = bus_q.pc;
      estat_ecode_d = ECODE_SYS;
      estat_esub_d  = 9'b0;
    end else if (wb_valid_q && bus_q.ertn) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end else if (csr_wr_en) begin
      case (bus_q.csr_num)
        CSR_CRMD: begin
          crmd_plv_d = csr_merged[1:0];
          crmd_ie_d  = csr_merged[2];
          crmd_da_d  = csr_merged[3];
        end
        CSR_PRMD: begin
          prmd_pplv_d = csr_merged[1:0];
          prmd_pie_d  = csr_merged[2];
        end
        CSR_ESTAT:  estat_is_d  = csr_merged[1:0];
        CSR_ERA:    era_d       = csr_merged;
        CSR_EENTRY: eentry_va_d = csr_merged[31:6];
        CSR_SAVE0:  save_d[0]   = csr_merged;
        CSR_SAVE1:  save_d[1]   = csr_merged;
        CSR_SAVE2:  save_d[2]   = csr_merged;
        CSR_SAVE3:  save_d[3]   = csr_merged;
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset; reset beats any commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
      wb_valid_q    <= 1'b0;
      bus_q         <= '0;
      crmd_plv_q    <= 2'b0;
      crmd_ie_q     <= 1'b0;
      crmd_da_q     <= 1'b1;
      prmd_pplv_q   <= 2'b0;
      prmd_pie_q    <= 1'b0;
      estat_is_q    <= 2'b0;
      estat_ecode_q <= 6'b0;
      estat_esub_q  <= 9'b0;
      era_q         <= 32'b0;
      eentry_va_q   <= 26'b0;
      // NOTE: SAVE0-3 is a tiny register array, not RAM, so it is reset like any flop.
      for (int i = 0; i < 4; i++) save_q[i] <= 32'b0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      bus_q         <= bus_d;
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      crmd_da_q     <= crmd_da_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      estat_is_q    <= estat_is_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
      era_q         <= era_d;
      eentry_va_q   <= eentry_va_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  // Debug trace ports mirror the register-file commit, or are tied off.
`ifdef WB_DEBUG_TRACE_EN
  always_comb begin
    debug_wb_pc       = bus_q.pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`else
  always_comb begin
    debug_wb_pc       = 32'b0;
    debug_wb_rf_we    = 4'b0;
    debug_wb_rf_wnum  = 5'b0;
    debug_wb_rf_wdata = 32'b0;
  end
`endif

  // Instruction word is carried for completeness but not used in WB.
  logic unused_bits;
  assign unused_bits = ^{bus_q.rsvd, bus_q.inst};

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_wb_stage;

  logic        clk;
  logic        resetn;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_ex;
  logic [31:0] flush_pc;
  logic [53:0] wb_id_bus;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage_if u_if ();

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_wb            (u_if.slave),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .wb_ex             (wb_ex),
    .flush_pc          (flush_pc),
    .wb_id_bus         (wb_id_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // CSRs are held as whole 32-bit words; a per-CSR writable mask decides
  // which bits software may change.
  logic [31:0]  m_crmd, m_prmd, m_estat, m_era, m_eentry;
  logic [31:0]  m_save [4];
  logic         m_valid;
  logic [184:0] m_bus;

  function automatic logic [31:0] m_read(input logic [13:0] num);
    case (num)
      14'h000: return m_crmd;
      14'h001: return m_prmd;
      14'h005: return m_estat;
      14'h006: return m_era;
      14'h00C: return m_eentry;
      14'h030: return m_save[0];
      14'h031: return m_save[1];
      14'h032: return m_save[2];
      14'h033: return m_save[3];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] sw_mask(input logic [13:0] num);
    case (num)
      14'h000: return 32'h0000_000F;
      14'h001: return 32'h0000_0007;
      14'h005: return 32'h0000_0003;
      14'h00C: return 32'hFFFF_FFC0;
      14'h006, 14'h030, 14'h031, 14'h032, 14'h033: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [13:0] num, input logic [31:0] v);
    case (num)
      14'h000: m_crmd   = v;
      14'h001: m_prmd   = v;
      14'h005: m_estat  = v;
      14'h006: m_era    = v;
      14'h00C: m_eentry = v;
      14'h030: m_save[0] = v;
      14'h031: m_save[1] = v;
      14'h032: m_save[2] = v;
      14'h033: m_save[3] = v;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_crmd = 32'h8; m_prmd = 0; m_estat = 0; m_era = 0; m_eentry = 0;
    for (int i = 0; i < 4; i++) m_save[i] = 0;
    m_valid = 1'b0;
    m_bus   = '0;
  endtask

  // Architectural effect of the instruction leaving WB.
  task automatic m_commit(input logic [184:0] b);
    logic [31:0] old_v, new_v, wm;
    if (b[0]) begin
      m_prmd  = {29'b0, m_crmd[2:0]};
      m_crmd  = m_crmd & ~32'h7;
      m_era   = b[182:151];
      m_estat = (m_estat & 32'h3) | (32'h0B << 16);
    end else if (b[1]) begin
      m_crmd = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
    end else if (b[81]) begin
      old_v = m_read(b[79:66]);
      new_v = (old_v & ~b[65:34]) | (b[33:2] & b[65:34]);
      wm    = sw_mask(b[79:66]);
      m_store(b[79:66], (old_v & ~wm) | (new_v & wm));
    end
  endtask

  task automatic m_edge(input logic rst_n_v, input logic v, input logic [184:0] b);
    if (!rst_n_v) m_reset();
    else begin
      if (m_valid) m_commit(m_bus);
      m_valid = v;
      if (v) m_bus = b;
    end
  endtask

  // Compare every DUT output against the model for the instruction in WB.
  task automatic compare_all();
    logic        e_ex, e_we, e_sys;
    logic [31:0] e_wdata, e_flush;
    e_sys   = m_bus[0];
    e_ex    = m_valid & (m_bus[0] | m_bus[1]);
    e_we    = m_valid & m_bus[183] & ~e_ex;
    e_wdata = m_bus[80] ? m_read(m_bus[79:66]) : m_bus[118:87];
    e_flush = e_sys ? (m_eentry & 32'hFFFF_FFC0) : m_era;
    check("allowin", 64'(u_if.wb_allowin), 64'd1);
    check("wb_ex",    64'(wb_ex), 64'(e_ex));
    check("rf_we",    64'(rf_we), 64'(e_we));
    check("rf_waddr", 64'(rf_waddr), 64'(m_bus[86:82]));
    check("rf_wdata", 64'(rf_wdata), 64'(e_wdata));
    if (e_ex) check("flush_pc", 64'(flush_pc), 64'(e_flush));
    check("wb_id_bus", 64'(wb_id_bus),
          64'({m_valid & m_bus[183], m_bus[86:82], e_wdata, m_bus[183],
               m_valid & (m_bus[81] | m_bus[80]), m_bus[79:66]}));
`ifdef WB_DEBUG_TRACE_EN
    check("dbg", {debug_wb_pc, 32'(debug_wb_rf_we)}, {m_bus[182:151], 32'({4{e_we}})});
    check("dbg_w", {27'(debug_wb_rf_wnum), debug_wb_rf_wdata}, {27'(m_bus[86:82]), e_wdata});
`else
    check("dbg", {debug_wb_pc, 32'(debug_wb_rf_we)}, 64'd0);
    check("dbg_w", {27'(debug_wb_rf_wnum), debug_wb_rf_wdata}, 64'd0);
`endif
  endtask

  // One clock: drive inputs (away from the edge), edge, model update, sample at negedge.
  task automatic cycle(input logic rst_n_v, input logic v, input logic [184:0] b);
    resetn            = rst_n_v;
    u_if.mem_wb_valid = v;
    u_if.mem_wb_bus   = b;
    @(posedge clk);
    m_edge(rst_n_v, v, b);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [184:0] mk(
      input logic gr_we, input logic [31:0] pc, input logic [31:0] fr, input logic [4:0] dest,
      input logic csr_we, input logic csr_re, input logic [13:0] num,
      input logic [31:0] wmask, input logic [31:0] wval, input logic ertn, input logic sys);
    return {1'b0, gr_we, pc, 32'h0, fr, dest, csr_we, csr_re, num, wmask, wval, ertn, sys};
  endfunction

  function automatic logic [184:0] csrrd(input logic [13:0] num, input logic [4:0] dest);
    return mk(1'b1, 32'h1C00_0040, 32'h0, dest, 1'b0, 1'b1, num, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic logic [184:0] csrwr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
    return mk(1'b0, 32'h1C00_0020, 32'h0, 5'd0, 1'b1, 1'b0, num, m, v, 1'b0, 1'b0);
  endfunction

  localparam logic [184:0] NOP = '0;

  initial begin
    logic [191:0] rnd;
    logic [184:0] b;
    logic [13:0]  nums [9];
    int           r;
    nums = '{14'h000, 14'h001, 14'h005, 14'h006, 14'h00C, 14'h030, 14'h031, 14'h032, 14'h033};
    m_reset();

    // Reset
    cycle(1'b0, 1'b0, NOP);
    cycle(1'b0, 1'b0, NOP);
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_wb_ex", 64'(wb_ex), 64'd0);

    // csrrd CRMD right after reset
    cycle(1'b1, 1'b1, csrrd(14'h000, 5'd4));
    check("crmd_rst_rd", 64'(rf_wdata), 64'h8);
    check("crmd_rst_addr", 64'(rf_waddr), 64'd4);
    check("crmd_rst_ex", 64'(wb_ex), 64'd0);

    // ALU commit
    cycle(1'b1, 1'b1, mk(1'b1, 32'h1C00_0000, 32'h1234, 5'd5, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    check("alu_we", 64'(rf_we), 64'd1);
    check("alu_addr", 64'(rf_waddr), 64'd5);
    check("alu_data", 64'(rf_wdata), 64'h1234);
    check("alu_bypass", 64'(wb_id_bus[53]), 64'd1);
    check("alu_dbg_we", 64'(debug_wb_rf_we),
`ifdef WB_DEBUG_TRACE_EN
          64'hF);
`else
          64'h0);
`endif

    // SAVE0 masked writes, then back-to-back read
    cycle(1'b1, 1'b1, csrwr(14'h030, 32'hFFFF_FFFF, 32'hDEAD_BEEF));
    cycle(1'b1, 1'b1, csrwr(14'h030, 32'h0000_FFFF, 32'h1234_5678));
    cycle(1'b1, 1'b1, csrrd(14'h030, 5'd6));
    check("save0_rd", 64'(rf_wdata), 64'hDEAD_5678);

    // Syscall: EENTRY=0x1C008000, CRMD=0xB (PLV=3, IE=0, DA=1)
    cycle(1'b1, 1'b1, csrwr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8000));
    cycle(1'b1, 1'b1, csrwr(14'h000, 32'hFFFF_FFFF, 32'h0000_000B));
    cycle(1'b1, 1'b1, mk(1'b1, 32'h1C00_0100, 32'h99, 5'd9, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b1));
    check("sys_ex", 64'(wb_ex), 64'd1);
    check("sys_flush", 64'(flush_pc), 64'h1C00_8000);
    check("sys_rf_we", 64'(rf_we), 64'd0);
    cycle(1'b1, 1'b1, csrrd(14'h006, 5'd1));
    check("sys_ex_once", 64'(wb_ex), 64'd0);
    check("sys_era", 64'(rf_wdata), 64'h1C00_0100);
    cycle(1'b1, 1'b1, csrrd(14'h005, 5'd1));
    check("sys_estat", 64'(rf_wdata), 64'h000B_0000);
    cycle(1'b1, 1'b1, csrrd(14'h001, 5'd1));
    check("sys_prmd", 64'(rf_wdata), 64'h3);   // PPLV=3, PIE=CRMD.IE=0
    cycle(1'b1, 1'b1, csrrd(14'h000, 5'd1));
    check("sys_crmd", 64'(rf_wdata), 64'h8);

    // Ertn returns to ERA and restores PLV/IE
    cycle(1'b1, 1'b1, mk(1'b0, 32'h1C00_0200, 32'h0, 5'd0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b0));
    check("ertn_ex", 64'(wb_ex), 64'd1);
    check("ertn_flush", 64'(flush_pc), 64'h1C00_0100);
    cycle(1'b1, 1'b1, csrrd(14'h000, 5'd2));
    check("ertn_crmd", 64'(rf_wdata), 64'hB);

    // Exception beats a simultaneous CSR write
    cycle(1'b1, 1'b1, mk(1'b0, 32'h1C00_0300, 32'h0, 5'd0, 1'b1, 1'b0, 14'h031, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b1, 1'b0));
    cycle(1'b1, 1'b1, csrrd(14'h031, 5'd3));
    check("ex_beats_wr", 64'(rf_wdata), 64'h0);

    // Reset mid-operation discards the in-flight CSR write
    cycle(1'b1, 1'b1, csrwr(14'h032, 32'hFFFF_FFFF, 32'h5555_AAAA));
    cycle(1'b0, 1'b0, NOP);
    check("midrst_we", 64'(rf_we), 64'd0);
    cycle(1'b1, 1'b1, csrrd(14'h032, 5'd7));
    check("midrst_save2", 64'(rf_wdata), 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b = rnd[184:0];
      r = int'($urandom_range(0, 9));
      b[79:66] = (r == 9) ? b[79:66] : nums[r];
      if ($urandom_range(0, 3) == 0) b[65:34] = 32'hFFFF_FFFF;
      r = int'($urandom_range(0, 99));
      b[1:0] = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : 2'b00;
      cycle(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
